// File: rtl/comp_sel_seq_if.sv
// Bus between the compensator sequencer and its ADC/PWM neighbours.
// Carries the sample handshake, the datapath select/load outputs and an FSM debug view.
interface comp_sel_seq_if #(
  parameter int WORD = 10
);
  logic            START;
  logic            ABORT;
  logic [WORD-1:0] ADC_D;
  logic [WORD-1:0] SAMPLE;
  logic [4:0]      S5;
  logic [1:0]      S2;
  logic            LD;
  logic            BUSY;
  logic            DONE;
  logic            OVR;
  logic            dbg_step;
  logic [2:0]      dbg_k;
  logic [3:0]      dbg_c;

  modport master (
    output START, ABORT, ADC_D,
    input  SAMPLE, S5, S2, LD, BUSY, DONE, OVR, dbg_step, dbg_k, dbg_c
  );

  modport slave (
    input  START, ABORT, ADC_D,
    output SAMPLE, S5, S2, LD, BUSY, DONE, OVR, dbg_step, dbg_k, dbg_c
  );
endinterface

// File: rtl/comp_sel_seq.sv
// Steps the compensator datapath through five operand selections per ADC sample,
// holding each for SETTLE cycles and strobing the register bank on the last one.
module comp_sel_seq #(
  parameter int WORD   = 10,
  parameter int SETTLE = 2
) (
  input  logic         CLK,
  input  logic         R,
  comp_sel_seq_if.slave bus
);
  // START is a single-cycle sample-valid pulse; it is only accepted in IDLE
  // (which includes the DONE cycle). ABORT has priority over START everywhere.

  typedef enum logic {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_e;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);
  localparam logic [2:0] K_LAST   = 3'd4;
  localparam logic       LD_FIRST = (SETTLE_C == 4'd1);

  state_e          state_q;
  logic [2:0]      k_q, k_d;
  logic [3:0]      c_q, c_d;
  logic [WORD-1:0] sample_q;
  logic [4:0]      s5_q;
  logic [1:0]      s2_q;
  logic            ld_q;
  logic            busy_q;
  logic            done_q;
  logic            ovr_q;

  function automatic logic [4:0] sel5(input logic [2:0] k);
    return 5'b10000 >> k;
  endfunction

  always_comb begin
    k_d = k_q + 3'd1;
    c_d = c_q + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q  <= IDLE;
      k_q      <= 3'd0;
      c_q      <= 4'd0;
      sample_q <= '0;
      s5_q     <= 5'b00000;
      s2_q     <= 2'b00;
      ld_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.START && !bus.ABORT) begin
            state_q  <= STEP;
            k_q      <= 3'd0;
            c_q      <= 4'd1;
            sample_q <= bus.ADC_D;
            ovr_q    <= 1'b0;
            s5_q     <= sel5(3'd0);
            s2_q     <= 2'b10;
            busy_q   <= 1'b1;
            ld_q     <= LD_FIRST;
          end
        end
        STEP: begin
          if (bus.START) ovr_q <= 1'b1;
          if (bus.ABORT || (c_q == SETTLE_C && k_q == K_LAST)) begin
            // Abort and normal completion share the return path; only completion pulses DONE.
            state_q <= IDLE;
            k_q     <= 3'd0;
            c_q     <= 4'd0;
            s5_q    <= 5'b00000;
            s2_q    <= 2'b00;
            ld_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= !bus.ABORT;
          end else if (c_q == SETTLE_C) begin
            k_q  <= k_d;
            c_q  <= 4'd1;
            s5_q <= sel5(k_d);
            s2_q <= 2'b01;
            ld_q <= LD_FIRST;
          end else begin
            c_q  <= c_d;
            ld_q <= (c_d == SETTLE_C);
          end
        end
      endcase
    end
  end

  assign bus.SAMPLE   = sample_q;
  assign bus.S5       = s5_q;
  assign bus.S2       = s2_q;
  assign bus.LD       = ld_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.OVR      = ovr_q;
  assign bus.dbg_step = (state_q == STEP);
  assign bus.dbg_k    = k_q;
  assign bus.dbg_c    = c_q;
endmodule

// File: doc/comp_sel_seq.md
# comp_sel_seq

Sequencer that drives the one-hot select codes and register load strobe of the compensator's time-multiplexed datapath. It sits directly upstream of the arrayed 5-input and 2-input muxes and the arrayed DFF bank. On each ADC sample-valid pulse it captures the sample and steps the datapath through five operand selections, each held for a programmable settle time. It then flags completion to the PWM update logic.

## Interface
Parameters:
- WORD, 10, width of ADC sample and captured SAMPLE
- SETTLE, 2, cycles each step is held (legal range 1..15)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- R  in  1  reset, synchronous, active-high
- START  in  1  ADC sample-valid pulse
- ABORT  in  1  cancel current sequence
- ADC_D  in  WORD  ADC sample, valid when START=1
- SAMPLE  out  WORD  captured ADC_D, held until next accepted START
- S5  out  5  one-hot select to 5-input arrayed mux (10000=A … 00001=E, 00000=none)
- S2  out  2  select to 2-input accumulator mux (10=fresh, 01=accumulate, 00=none)
- LD  out  1  load enable for datapath register bank
- BUSY  out  1  sequence in progress
- DONE  out  1  one-cycle completion pulse
- OVR  out  1  sticky overrun: START arrived while BUSY

## Operation
- States: IDLE, STEP (with step index k=0..4 and settle counter c=1..SETTLE).
- Reset (R=1 at an edge): next cycle SAMPLE=0, S5=00000, S2=00, LD=0, BUSY=0, DONE=0, OVR=0, state IDLE. Overrides every other input, including mid-sequence.
- IDLE, START=1, ABORT=0: SAMPLE<=ADC_D, OVR<=0, enter STEP k=0 c=1.
- IDLE, START=1, ABORT=1: ABORT wins; no capture, stay IDLE.
- STEP: S5 = one-hot bit (4-k), i.e. k=0→10000, k=4→00001.
- STEP: S2=10 for k=0, 01 for k=1..4.
- STEP: LD=1 only when c=SETTLE. At that point, if k<4, go to k+1 with c=1; if k=4, go to IDLE with DONE=1 on the following cycle.
- STEP, otherwise c increments; k unchanged.
- STEP, START=1: ignored for sequencing. SAMPLE unchanged, OVR<=1 (sticky until next accepted START or reset).
- STEP, ABORT=1: next cycle IDLE, all selects 00000/00, LD=0, BUSY=0, no DONE; SAMPLE and OVR retained. If ABORT coincides with the final LD cycle, LD still asserts that cycle but DONE is suppressed.
- In IDLE and in the DONE cycle, S5=00000 and S2=00, so downstream muxes output 0.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- START accepted at edge t → from cycle t+1: BUSY=1, S5=10000, S2=10, SAMPLE valid.
- Step k occupies cycles t+1+k·SETTLE … t+(k+1)·SETTLE; LD=1 on the last cycle of each.
- Exactly 5 LD pulses per completed sequence.
- DONE=1 for one cycle at t+5·SETTLE+1, with BUSY=0 and S5=00000.
- START is accepted in the DONE cycle (back-to-back sequences, one idle cycle minimum).
- SETTLE=1: LD=1 on every BUSY cycle; S5 changes every cycle.
- Settle counter width is 4 bits; k counter is 3 bits. k never exceeds 4.

## Test plan
- Reset, then START with ADC_D=10'h2A5 at edge t (SETTLE=2) → SAMPLE=2A5 from t+1; S5 = 10000,10000,01000,01000,…,00001,00001; S2 = 10,10 then 01 ×8; LD at t+2,4,6,8,10; DONE at t+11 only; BUSY t+1..t+10.
- START again at t+5 mid-sequence with ADC_D=10'h3FF → SAMPLE stays 2A5, OVR=1 from t+6, sequence timing unchanged. A new START after DONE clears OVR and captures the new sample.
- ABORT at t+4 → cycle t+5: BUSY=0, S5=00000, LD=0; no DONE ever. START=ABORT=1 in IDLE → no capture, stays IDLE.
- R=1 at t+6 mid-sequence → from t+7: all outputs 0, including SAMPLE and OVR. START at t+8 runs a full sequence normally.
- SETTLE=1 → LD on 5 consecutive cycles t+1..t+5, DONE at t+6. START in the DONE cycle → new BUSY at t+7.
